// File: rtl/id_ex_skid_register_if.sv
// ============================================================================
// id_ex_skid_register_if : decode / writeback / execute bundle for the ID/EX stage
// Revision: 1.0
// ============================================================================
`default_nettype none

interface id_ex_skid_register_if #(
    parameter int N = 5,
    parameter int M = 32,
    parameter int C = 16
);
    logic         id_valid;
    logic         id_ready;
    logic [N-1:0] id_rs1;
    logic [N-1:0] id_rs2;
    logic [N-1:0] id_rd;
    logic [M-1:0] id_rd1;
    logic [M-1:0] id_rd2;
    logic [M-1:0] id_imm;
    logic [M-1:0] id_pc;
    logic [C-1:0] id_ctrl;

    logic         wb_we;
    logic [N-1:0] wb_a3;
    logic [M-1:0] wb_wd3;

    logic         ex_valid;
    logic         ex_ready;
    logic [N-1:0] ex_rs1;
    logic [N-1:0] ex_rs2;
    logic [N-1:0] ex_rd;
    logic [M-1:0] ex_rd1;
    logic [M-1:0] ex_rd2;
    logic [M-1:0] ex_imm;
    logic [M-1:0] ex_pc;
    logic [C-1:0] ex_ctrl;

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_rd1, id_rd2, id_imm, id_pc, id_ctrl,
        input  wb_we, wb_a3, wb_wd3,
        input  ex_ready,
        output id_ready,
        output ex_valid, ex_rs1, ex_rs2, ex_rd, ex_rd1, ex_rd2, ex_imm, ex_pc, ex_ctrl
    );

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_rd1, id_rd2, id_imm, id_pc, id_ctrl,
        output wb_we, wb_a3, wb_wd3,
        output ex_ready,
        input  id_ready,
        input  ex_valid, ex_rs1, ex_rs2, ex_rd, ex_rd1, ex_rd2, ex_imm, ex_pc, ex_ctrl
    );
endinterface

`default_nettype wire

// File: rtl/id_ex_skid_register.sv
// ============================================================================
// id_ex_skid_register : 2-entry skid-buffered ID/EX stage with writeback bypass
// Optional macro ID_EX_PERF_CNT_EN adds stall_cnt / bubble_cnt counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module id_ex_skid_register #(
    parameter int N = 5,
    parameter int M = 32,
    parameter int C = 16
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               flush,
    id_ex_skid_register_if.slave    bus
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]             stall_cnt,
    output logic [31:0]             bubble_cnt
`endif
);

    typedef struct packed {
        logic [N-1:0] rs1;
        logic [N-1:0] rs2;
        logic [N-1:0] rd;
        logic [M-1:0] rd1;
        logic [M-1:0] rd2;
        logic [M-1:0] imm;
        logic [M-1:0] pc;
        logic [C-1:0] ctrl;
    } entry_t;

    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   main_v_q, main_v_d;
    logic   skid_v_q, skid_v_d;
    logic   id_ready_q, id_ready_d;

    entry_t w_in;
    logic   w_accept;
    logic   w_drain;

    // Held operands track writes to their source registers; x0 is hardwired zero.
    function automatic entry_t bypass(input entry_t e, input logic we,
                                      input logic [N-1:0] a3, input logic [M-1:0] wd);
        entry_t r;
        r = e;
        if (we && (a3 != '0) && (a3 == e.rs1)) r.rd1 = wd;
        if (we && (a3 != '0) && (a3 == e.rs2)) r.rd2 = wd;
        return r;
    endfunction

    assign w_in = '{rs1: bus.id_rs1, rs2: bus.id_rs2, rd: bus.id_rd,
                    rd1: bus.id_rd1, rd2: bus.id_rd2, imm: bus.id_imm,
                    pc: bus.id_pc, ctrl: bus.id_ctrl};

    assign w_accept = bus.id_valid && id_ready_q;
    assign w_drain  = main_v_q && bus.ex_ready;

    always_comb begin
        main_d   = main_q;
        skid_d   = skid_q;
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        if (flush) begin
            main_v_d    = 1'b0;
            skid_v_d    = 1'b0;
            main_d.ctrl = '0;
        end else if (main_v_q && !w_drain) begin
            main_d = bypass(main_q, bus.wb_we, bus.wb_a3, bus.wb_wd3);
            if (skid_v_q) begin
                skid_d = bypass(skid_q, bus.wb_we, bus.wb_a3, bus.wb_wd3);
            end else if (w_accept) begin
                skid_d   = w_in;
                skid_v_d = 1'b1;
            end
        end else if (skid_v_q) begin
            // Skid advances into main; any new accept refills the skid slot.
            main_d   = bypass(skid_q, bus.wb_we, bus.wb_a3, bus.wb_wd3);
            main_v_d = 1'b1;
            skid_v_d = w_accept;
            if (w_accept) skid_d = w_in;
        end else begin
            main_v_d = w_accept;
            if (w_accept) main_d = w_in;
            else          main_d.ctrl = '0;
        end
        id_ready_d = !skid_v_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_v_q   <= 1'b0;
            skid_v_q   <= 1'b0;
            id_ready_q <= 1'b1;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_v_q   <= main_v_d;
            skid_v_q   <= skid_v_d;
            id_ready_q <= id_ready_d;
        end
    end

    assign bus.id_ready = id_ready_q;
    assign bus.ex_valid = main_v_q;
    assign bus.ex_rs1   = main_q.rs1;
    assign bus.ex_rs2   = main_q.rs2;
    assign bus.ex_rd    = main_q.rd;
    assign bus.ex_rd1   = main_q.rd1;
    assign bus.ex_rd2   = main_q.rd2;
    assign bus.ex_imm   = main_q.imm;
    assign bus.ex_pc    = main_q.pc;
    assign bus.ex_ctrl  = main_q.ctrl;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] bubble_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else if (!flush) begin
            if (bus.id_valid && !id_ready_q) stall_cnt_q  <= stall_cnt_q + 32'd1;
            if (bus.ex_ready && !main_v_q)   bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_ex_skid_register.sv
// ============================================================================
// tb_id_ex_skid_register : directed self-checking bench for id_ex_skid_register
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_id_ex_skid_register;

    logic clk;
    logic rst_n;
    logic flush;
    int   errors;
    int   checks;

    id_ex_skid_register_if #(.N(5), .M(32), .C(16)) bus ();

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] bubble_cnt;
`endif

    id_ex_skid_register #(.N(5), .M(32), .C(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .bus        (bus)
`ifdef ID_EX_PERF_CNT_EN
        ,
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] pc, input logic [15:0] ctrl,
                           input logic [4:0] rs1, input logic [31:0] rd1,
                           input logic [4:0] rs2, input logic [31:0] rd2);
        bus.id_valid = 1'b1;
        bus.id_pc    = pc;
        bus.id_ctrl  = ctrl;
        bus.id_rs1   = rs1;
        bus.id_rd1   = rd1;
        bus.id_rs2   = rs2;
        bus.id_rd2   = rd2;
        bus.id_rd    = 5'd1;
        bus.id_imm   = pc + 32'd100;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        bus.id_valid = 1'b0;
        bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rd = '0;
        bus.id_rd1 = '0; bus.id_rd2 = '0; bus.id_imm = '0;
        bus.id_pc = '0;  bus.id_ctrl = '0;
        bus.wb_we = 1'b0; bus.wb_a3 = '0; bus.wb_wd3 = '0;
        bus.ex_ready = 1'b1;

        #12;
        check("rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("rst_id_ready", {31'd0, bus.id_ready}, 32'd1);
        check("rst_ex_ctrl",  {16'd0, bus.ex_ctrl},  32'd0);
        check("rst_ex_pc",    bus.ex_pc,             32'd0);
        rst_n = 1'b1;

        // Back-to-back stream at full throughput
        for (int i = 0; i < 8; i++) begin
            present(32'(i * 4), 16'(i + 1), 5'd0, 32'd0, 5'd0, 32'd0);
            tick();
            check("stream_valid", {31'd0, bus.ex_valid}, 32'd1);
            check("stream_pc",    bus.ex_pc,             32'(i * 4));
            check("stream_ctrl",  {16'd0, bus.ex_ctrl},  32'(i + 1));
            check("stream_ready", {31'd0, bus.id_ready}, 32'd1);
        end
        bus.id_valid = 1'b0;
        tick();
        check("stream_end_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("stream_end_ctrl",  {16'd0, bus.ex_ctrl},  32'd0);

        // Backpressure: two held, third waits upstream
        bus.ex_ready = 1'b0;
        present(32'h40, 16'h40, 5'd0, 32'd0, 5'd0, 32'd0);
        tick();
        check("bp_pc40",     bus.ex_pc,             32'h40);
        check("bp_ready1",   {31'd0, bus.id_ready}, 32'd1);
        present(32'h44, 16'h44, 5'd0, 32'd0, 5'd0, 32'd0);
        tick();
        check("bp_ready0",   {31'd0, bus.id_ready}, 32'd0);
        check("bp_hold40",   bus.ex_pc,             32'h40);
        present(32'h48, 16'h48, 5'd0, 32'd0, 5'd0, 32'd0);
        tick();
        check("bp_still40",  bus.ex_pc,             32'h40);
        check("bp_still0",   {31'd0, bus.id_ready}, 32'd0);
        bus.ex_ready = 1'b1;
        tick();
        check("bp_pc44",     bus.ex_pc,             32'h44);
        check("bp_ready_back", {31'd0, bus.id_ready}, 32'd1);
        tick();
        check("bp_pc48",     bus.ex_pc,             32'h48);
        check("bp_valid48",  {31'd0, bus.ex_valid}, 32'd1);
        bus.id_valid = 1'b0;
        tick();
        check("bp_no_dup",   {31'd0, bus.ex_valid}, 32'd0);

        // Writeback bypass on held entries
        bus.ex_ready = 1'b0;
        present(32'h60, 16'h60, 5'd9, 32'd4, 5'd3, 32'd7);
        tick();
        bus.id_valid = 1'b0;
        check("byp_rd1_init", bus.ex_rd1, 32'd4);
        bus.wb_we = 1'b1; bus.wb_a3 = 5'd9; bus.wb_wd3 = 32'd14;
        tick();
        check("byp_rd1_14",  bus.ex_rd1, 32'd14);
        check("byp_rd2_keep", bus.ex_rd2, 32'd7);
        bus.wb_a3 = 5'd0; bus.wb_wd3 = 32'd55;
        tick();
        check("byp_a3zero_rd1", bus.ex_rd1, 32'd14);
        check("byp_a3zero_rd2", bus.ex_rd2, 32'd7);
        bus.wb_a3 = 5'd3; bus.wb_wd3 = 32'h33;
        tick();
        check("byp_rd2_33",  bus.ex_rd2, 32'h33);
        check("byp_rd1_same", bus.ex_rd1, 32'd14);
        // New entry captured unmodified while the held one is bypassed
        present(32'h80, 16'h0B, 5'd9, 32'd1, 5'd5, 32'd2);
        bus.wb_a3 = 5'd9; bus.wb_wd3 = 32'h77;
        tick();
        bus.id_valid = 1'b0;
        check("byp_main_77", bus.ex_rd1, 32'h77);
        check("byp_skid_full", {31'd0, bus.id_ready}, 32'd0);
        bus.ex_ready = 1'b1;
        bus.wb_a3 = 5'd5; bus.wb_wd3 = 32'h55;
        tick();
        bus.wb_we = 1'b0;
        check("byp_move_pc",  bus.ex_pc,  32'h80);
        check("byp_move_rd1", bus.ex_rd1, 32'd1);
        check("byp_move_rd2", bus.ex_rd2, 32'h55);
        tick();
        check("byp_empty",   {31'd0, bus.ex_valid}, 32'd0);

        // Flush with both entries held
        bus.ex_ready = 1'b0;
        present(32'hA0, 16'h1, 5'd0, 32'd0, 5'd0, 32'd0);
        tick();
        present(32'hA4, 16'h2, 5'd0, 32'd0, 5'd0, 32'd0);
        tick();
        present(32'hC0, 16'h3, 5'd0, 32'd0, 5'd0, 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus.id_valid = 1'b0;
        check("fl_valid",    {31'd0, bus.ex_valid}, 32'd0);
        check("fl_ctrl",     {16'd0, bus.ex_ctrl},  32'd0);
        check("fl_ready",    {31'd0, bus.id_ready}, 32'd1);
        bus.ex_ready = 1'b1;
        tick();
        check("fl_no_leak",  {31'd0, bus.ex_valid}, 32'd0);
        // Flush discards a same-cycle accept
        bus.ex_ready = 1'b0;
        present(32'hD0, 16'h4, 5'd0, 32'd0, 5'd0, 32'd0);
        tick();
        present(32'hD4, 16'h5, 5'd0, 32'd0, 5'd0, 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus.id_valid = 1'b0;
        check("fl2_valid",   {31'd0, bus.ex_valid}, 32'd0);
        check("fl2_ready",   {31'd0, bus.id_ready}, 32'd1);
        bus.ex_ready = 1'b1;
        tick();
        check("fl2_discard", {31'd0, bus.ex_valid}, 32'd0);

        // Asynchronous reset with both entries held
        bus.ex_ready = 1'b0;
        present(32'hE0, 16'h6, 5'd0, 32'd0, 5'd0, 32'd0);
        tick();
        present(32'hE4, 16'h7, 5'd0, 32'd0, 5'd0, 32'd0);
        tick();
        bus.id_valid = 1'b0;
        check("ar_full",     {31'd0, bus.id_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid",    {31'd0, bus.ex_valid}, 32'd0);
        check("ar_ctrl",     {16'd0, bus.ex_ctrl},  32'd0);
        check("ar_ready",    {31'd0, bus.id_ready}, 32'd1);
        #3;
        rst_n = 1'b1;
        bus.ex_ready = 1'b1;
        present(32'hF0, 16'h8, 5'd0, 32'd0, 5'd0, 32'd0);
        tick();
        bus.id_valid = 1'b0;
        check("ar_first_valid", {31'd0, bus.ex_valid}, 32'd1);
        check("ar_first_pc",    bus.ex_pc,             32'hF0);
        tick();

`ifdef ID_EX_PERF_CNT_EN
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        check("pc_rst_stall",  stall_cnt,  32'd0);
        check("pc_rst_bubble", bubble_cnt, 32'd0);
        bus.ex_ready = 1'b0;
        present(32'h100, 16'h1, 5'd0, 32'd0, 5'd0, 32'd0);
        tick();
        present(32'h104, 16'h2, 5'd0, 32'd0, 5'd0, 32'd0);
        tick();
        present(32'h108, 16'h3, 5'd0, 32'd0, 5'd0, 32'd0);
        tick();
        tick();
        tick();
        check("pc_stall3",     stall_cnt,  32'd3);
        check("pc_bubble0",    bubble_cnt, 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus.id_valid = 1'b0;
        check("pc_flush_stall", stall_cnt, 32'd3);
        bus.ex_ready = 1'b1;
        tick();
        tick();
        check("pc_bubble2",    bubble_cnt, 32'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/id_ex_skid_register.md
Name: id_ex_skid_register

Overview:
- Decode-to-execute pipeline stage placed directly downstream of the register file.
- Captures the register file read data `rd1`/`rd2` together with the source/destination indices, immediate, PC and control bundle.
- Hands these to execute through a valid/ready handshake, using a 2-entry skid buffer so that `id_ready` is a registered signal.
- Held operands are kept coherent with writeback writes that land while an entry is stalled.

Parameters:
- N, 5, register index width
- M, 32, data/PC width
- C, 16, decoded control bundle width

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  kill all held entries (branch/jump redirect)
- id_valid  input  1  decode presents an instruction
- id_ready  output  1  stage can accept; registered
- id_rs1, id_rs2  input  N  source indices (the `a1`/`a2` given to the register file)
- id_rd  input  N  destination index
- id_rd1, id_rd2  input  M  register file read data
- id_imm  input  M  extended immediate
- id_pc  input  M  instruction PC
- id_ctrl  input  C  decoded control bundle
- wb_we  input  1  writeback write enable (same as register file `we`)
- wb_a3  input  N  writeback index
- wb_wd3  input  M  writeback data
- ex_valid  output  1  entry presented to execute
- ex_ready  input  1  execute accepts
- ex_rs1, ex_rs2, ex_rd  output  N  held indices
- ex_rd1, ex_rd2, ex_imm, ex_pc  output  M  held data
- ex_ctrl  output  C  held control; all zeros whenever ex_valid=0

Behaviour:
- Storage: main entry (drives the ex_* outputs) plus skid entry; each has a valid bit.
- Reset (rst_n=0, asynchronous): both valid bits 0; every ex_* data output 0; id_ready=1.
- Accept: occurs when id_valid && id_ready at a rising edge. Drain: occurs when ex_valid && ex_ready.
- Entry movement:
  - Main empty, or main draining: the incoming entry goes to main.
  - Main full and not draining: the incoming entry goes to skid.
  - Main draining with skid valid: skid moves to main, and the new accept (if any) goes to skid.
- id_ready:
  - next value = !(skid valid after the edge).
  - Never depends combinationally on ex_ready.
- Latency:
  - 1 cycle from accept to ex_valid when main is empty or draining.
  - Full throughput with ex_ready=1.
  - After ex_ready drops, up to 2 entries are held and nothing is lost.
- Ordering: strictly FIFO; skid is always younger than main.
- Flush:
  - On the next edge both valid bits become 0 and ex_ctrl becomes 0.
  - Any accept in the same cycle is discarded.
  - id_ready is 1 the following cycle.
  - Flush has priority over accept, drain and bypass.
- Writeback bypass: at each edge, for every held entry that stays held or moves skid→main:
  - if wb_we && wb_a3 != 0 && wb_a3 == rs1, replace rd1 with wb_wd3;
  - apply the same rule for rs2/rd2.
  - Both operands may update in the same cycle.
  - Index 0 is never bypassed.
- Capture rule: a newly accepted entry stores id_rd1/id_rd2 unmodified. The register file writes on the falling edge, so its read data is already current at capture.
- A drained entry takes no bypass.
- ex_* outputs are driven only from flops, with no combinational path from id_* inputs.
- id_* values presented while id_ready=0 are ignored.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN
- Defined:
  - Adds outputs stall_cnt (32 bit) and bubble_cnt (32 bit); both reset to 0 and wrap at 2^32.
  - stall_cnt increments in each cycle where id_valid && !id_ready.
  - bubble_cnt increments in each cycle where ex_ready && !ex_valid.
  - A flush cycle counts toward neither.
- Undefined: these ports and counters do not exist; core behaviour is identical.

Test Plan:
- Reset check: drive rst_n=0 mid-stream with both entries held → ex_valid=0, ex_ctrl=0 and id_ready=1 immediately (asynchronously); after release, the first accept appears at the output 1 cycle later.
- Back-to-back throughput: stream 8 instructions (pc = 0x00, 0x04, …, 0x1C) with ex_ready=1 → ex_pc follows 1 cycle behind and ex_valid stays 1 for 8 consecutive cycles.
- Backpressure: hold ex_ready=0 while feeding pc 0x40, 0x44, 0x48 → id_ready falls after the 2nd accept and 0x48 is held upstream; release ex_ready → outputs 0x40, 0x44, 0x48 in order with no loss or duplication.
- Bypass while stalled:
  - Hold an entry with rs1=9 and rd1=4 under ex_ready=0, then pulse wb_we with a3=9, wd3=14 → ex_rd1 becomes 14 on the next edge.
  - Repeat with a3=0 → no change.
- Flush: with main and skid both valid, assert flush together with id_valid=1 → next cycle ex_valid=0, ex_ctrl=0, id_ready=1, and the presented instruction never appears at the output.
- Perf counters (macro defined): 3 cycles of id_valid under a full buffer → stall_cnt=3; 2 idle cycles with ex_ready=1 → bubble_cnt=2.
